// File: rtl/vga_capture.sv
// vga_capture: recovers pixel coordinates from hsync/vsync and gray video, writes active pixels to a frame buffer.
// Writes appear one cycle after the sampling edge; no backpressure, every write must be accepted.
module vga_capture #(
  parameter int H_ACTIVE   = 640,
  parameter int H_BACK     = 48,
  parameter int H_TOTAL    = 800,
  parameter int V_ACTIVE   = 480,
  parameter int V_BACK     = 33,
  parameter int V_TOTAL    = 525,
  parameter int PIX_OFFSET = 0,
  parameter int ADDR_W     = 19
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic [7:0]        pixel_in,
  input  logic              capture_en,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              frame_start,
  output logic              frame_done,
  output logic              locked,
  output logic              err_line,
  output logic              err_frame
);

  localparam logic [10:0]       PIX_LO    = 11'(H_BACK + PIX_OFFSET);
  localparam logic [10:0]       PIX_HI    = 11'(H_BACK + PIX_OFFSET + H_ACTIVE);
  localparam logic [10:0]       H_TOT     = 11'(H_TOTAL);
  localparam logic [9:0]        ROW_LO    = 10'(V_BACK);
  localparam logic [9:0]        ROW_HI    = 10'(V_BACK + V_ACTIVE);
  localparam logic [9:0]        V_TOT     = 10'(V_TOTAL);
  localparam logic [9:0]        CNT_MAX   = 10'd1023;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

  typedef enum logic [1:0] {IDLE, WAIT, CAPTURE} state_t;

  state_t            state, state_next;
  logic              hs_q, vs_q, hs_rise, vs_rise;
  logic [9:0]        h_cnt, line_cnt, line_next;
  logic [10:0]       h_len, pos;
  logic              h_ref, pix_ok;
  logic [ADDR_W-1:0] addr_cnt, wr_idx;
  logic              wr_d, start_d, done_d, err_line_d, err_frame_d;

  assign hs_rise = hsync_in & ~hs_q;
  assign vs_rise = vsync_in & ~vs_q;
  assign h_len   = {1'b0, h_cnt} + 11'd1;
  // Position of the sample taken at this edge, counted from the hsync rise edge.
  assign pos     = hs_rise ? 11'd0 : h_len;
  assign locked  = (state != IDLE);

  always_comb begin
    line_next = line_cnt;
    if (vs_rise)
      line_next = hs_rise ? 10'd1 : 10'd0;
    else if (hs_rise && line_cnt != CNT_MAX)
      line_next = line_cnt + 10'd1;
  end

  assign pix_ok = (pos >= PIX_LO) && (pos < PIX_HI) &&
                  (line_next > ROW_LO) && (line_next <= ROW_HI);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    start_d     = 1'b0;
    err_line_d  = 1'b0;
    err_frame_d = 1'b0;
    wr_d        = 1'b0;
    done_d      = 1'b0;
    if (vs_rise) begin
      if (state == IDLE) begin
        state_next = WAIT;
      end else begin
        err_frame_d = (line_cnt != V_TOT);
        if (capture_en) begin
          state_next = CAPTURE;
          start_d    = 1'b1;
        end else begin
          state_next = WAIT;
        end
      end
    end
    // h_ref is only ever set while locked, so it also gates the check to locked states.
    if (hs_rise && h_ref && h_len != H_TOT) begin
      err_line_d = 1'b1;
      start_d    = 1'b0;
      state_next = IDLE;
    end
    wr_idx = start_d ? '0 : addr_cnt;
    if (state_next == CAPTURE && pix_ok) begin
      wr_d = 1'b1;
      if (wr_idx == LAST_ADDR) begin
        done_d     = 1'b1;
        state_next = WAIT;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      h_cnt       <= '0;
      line_cnt    <= '0;
      h_ref       <= 1'b0;
      addr_cnt    <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      err_line    <= 1'b0;
      err_frame   <= 1'b0;
    end else begin
      hs_q        <= hsync_in;
      vs_q        <= vsync_in;
      line_cnt    <= line_next;
      wr_en       <= wr_d;
      frame_start <= start_d;
      frame_done  <= done_d;
      err_line    <= err_line_d;
      err_frame   <= err_frame_d;
      if (hs_rise)
        h_cnt <= '0;
      else if (h_cnt != CNT_MAX)
        h_cnt <= h_cnt + 10'd1;
      if (state_next == IDLE)
        h_ref <= 1'b0;
      else if (hs_rise)
        h_ref <= 1'b1;
      if (wr_d) begin
        wr_addr  <= wr_idx;
        wr_data  <= pixel_in;
        addr_cnt <= wr_idx + 1'b1;
      end else if (start_d) begin
        addr_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture: small 8x4 timing, frame-level vector table plus a mid-frame reset sequence.
// A second instance with PIX_OFFSET=2 sees the same pixel stream delayed by two cycles.
module tb_vga_capture;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       hsync_in = 1'b1;
  logic       vsync_in = 1'b1;
  logic       capture_en = 1'b0;
  logic [7:0] pixel_in = 8'h00;
  logic [7:0] pix_d1 = 8'h00;
  logic [7:0] pix_d2 = 8'h00;

  logic       wr_en, frame_start, frame_done, locked, err_line, err_frame;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_en2, frame_start2, frame_done2, locked2, err_line2, err_frame2;
  logic [4:0] wr_addr2;
  logic [7:0] wr_data2;

  vga_capture #(.H_ACTIVE(8), .H_BACK(2), .H_TOTAL(12), .V_ACTIVE(4), .V_BACK(2),
                .V_TOTAL(8), .PIX_OFFSET(0), .ADDR_W(5)) dut (
    .clock(clock), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .pixel_in(pixel_in), .capture_en(capture_en), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .frame_start(frame_start), .frame_done(frame_done),
    .locked(locked), .err_line(err_line), .err_frame(err_frame));

  vga_capture #(.H_ACTIVE(8), .H_BACK(2), .H_TOTAL(12), .V_ACTIVE(4), .V_BACK(2),
                .V_TOTAL(8), .PIX_OFFSET(2), .ADDR_W(5)) dut2 (
    .clock(clock), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .pixel_in(pix_d2), .capture_en(capture_en), .wr_en(wr_en2), .wr_addr(wr_addr2),
    .wr_data(wr_data2), .frame_start(frame_start2), .frame_done(frame_done2),
    .locked(locked2), .err_line(err_line2), .err_frame(err_frame2));

  always #5 clock = ~clock;

  always @(posedge clock) begin
    pix_d1 <= pixel_in;
    pix_d2 <= pix_d1;
  end

  int checks = 0;
  int errors = 0;
  int wcnt0, wcnt2, scnt, dcnt, elcnt, efcnt, done_addr, done_wr;
  logic [7:0] mem0 [32];
  logic [7:0] mem2 [32];

  always @(negedge clock) begin
    if (wr_en) begin
      wcnt0++;
      mem0[wr_addr] = wr_data;
    end
    if (wr_en2) begin
      wcnt2++;
      mem2[wr_addr2] = wr_data2;
    end
    if (frame_start) scnt++;
    if (frame_done) begin
      dcnt++;
      done_addr = int'(wr_addr);
      done_wr   = int'(wr_en);
    end
    if (err_line)  elcnt++;
    if (err_frame) efcnt++;
  end

  typedef struct {
    int nlines;
    int short_k;
    int cap;
    int cap_on_k;
    int w0;
    int w2;
    int starts;
    int dones;
    int el;
    int ef;
    int lk;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_counts();
    wcnt0 = 0; wcnt2 = 0; scnt = 0; dcnt = 0; elcnt = 0; efcnt = 0;
    done_addr = -1; done_wr = 0;
    for (int k = 0; k < 32; k++) begin
      mem0[k] = 8'hEE;
      mem2[k] = 8'hEE;
    end
  endtask

  // Lines are 12 cycles (hsync low in the last two), vsync low for the whole last line.
  task automatic run_frame(input int nlines, input int short_k, input int cap_on_k);
    int len;
    for (int k = 0; k < nlines; k++) begin
      len = (k == short_k) ? 11 : 12;
      if (k == cap_on_k) capture_en = 1'b1;
      for (int c = 0; c < len; c++) begin
        hsync_in = (c < len - 2) ? 1'b1 : 1'b0;
        vsync_in = (k != nlines - 1) ? 1'b1 : 1'b0;
        if (k >= 2 && k < 6 && c >= 2 && c < 10)
          pixel_in = 8'(((k - 2) << 4) | (c - 2));
        else
          pixel_in = 8'h00;
        tick();
      end
    end
  endtask

  task automatic apply_vec(input int i);
    int bad0, bad2;
    logic [7:0] expv;
    clear_counts();
    capture_en = (vecs[i].cap != 0) ? 1'b1 : 1'b0;
    run_frame(vecs[i].nlines, vecs[i].short_k, vecs[i].cap_on_k);
    #1;
    check($sformatf("f%0d_writes", i), wcnt0, vecs[i].w0);
    check($sformatf("f%0d_writes_off2", i), wcnt2, vecs[i].w2);
    check($sformatf("f%0d_frame_start", i), scnt, vecs[i].starts);
    check($sformatf("f%0d_frame_done", i), dcnt, vecs[i].dones);
    check($sformatf("f%0d_err_line", i), elcnt, vecs[i].el);
    check($sformatf("f%0d_err_frame", i), efcnt, vecs[i].ef);
    check($sformatf("f%0d_locked", i), int'(locked), vecs[i].lk);
    if (vecs[i].w0 == 32) begin
      bad0 = 0;
      bad2 = 0;
      for (int k = 0; k < 32; k++) begin
        expv = 8'(((k / 8) << 4) | (k % 8));
        if (mem0[k] != expv) bad0++;
        if (mem2[k] != expv) bad2++;
      end
      check($sformatf("f%0d_bad_pixels", i), bad0, 0);
      check($sformatf("f%0d_bad_pixels_off2", i), bad2, 0);
      check($sformatf("f%0d_done_addr", i), done_addr, 31);
      check($sformatf("f%0d_done_with_write", i), done_wr, 1);
    end
  endtask

  int snap;
  int waited;

  initial begin
    //            nl sk cap con  w0  w2 st dn el ef lk
    vecs[0]  = '{8, -1, 1, -1,  0,  0, 0, 0, 0, 0, 1};  // first vsync only locks
    vecs[1]  = '{8, -1, 1, -1, 32, 32, 1, 1, 0, 0, 1};
    vecs[2]  = '{8,  3, 1, -1, 16, 15, 1, 0, 1, 0, 0};  // row 1 is 11 cycles long
    vecs[3]  = '{8, -1, 1, -1,  0,  0, 0, 0, 0, 0, 1};  // relock
    vecs[4]  = '{8, -1, 1, -1, 32, 32, 1, 1, 0, 0, 1};
    vecs[5]  = '{9, -1, 1, -1, 32, 32, 1, 1, 0, 0, 1};  // 9-line frame
    vecs[6]  = '{8, -1, 1, -1, 32, 32, 1, 1, 0, 1, 1};  // its length is flagged here
    vecs[7]  = '{8, -1, 0,  1,  0,  0, 0, 0, 0, 0, 1};  // armed too late
    vecs[8]  = '{8, -1, 1, -1, 32, 32, 1, 1, 0, 0, 1};
    vecs[9]  = '{8, -1, 1, -1,  0,  0, 0, 0, 0, 0, 1};  // relock after reset
    vecs[10] = '{8, -1, 1, -1, 32, 32, 1, 1, 0, 0, 1};

    clear_counts();
    repeat (3) tick();
    check("rst_wr_en", int'(wr_en), 0);
    check("rst_wr_addr", int'(wr_addr), 0);
    check("rst_wr_data", int'(wr_data), 0);
    check("rst_frame_start", int'(frame_start), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_err_line", int'(err_line), 0);
    check("rst_err_frame", int'(err_frame), 0);

    reset = 1'b0;
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    repeat (3) tick();
    check("pre_lock_locked", int'(locked), 0);

    for (int i = 0; i < 9; i++) apply_vec(i);

    // Reset lands while the 10th write of a captured frame is on the bus.
    clear_counts();
    capture_en = 1'b1;
    snap = 0;
    fork
      run_frame(8, -1, -1);
      begin
        waited = 0;
        while (wcnt0 < 10 && waited < 400) begin
          @(negedge clock);
          #2;
          waited++;
        end
        check("rst_trigger_reached", (wcnt0 >= 10) ? 1 : 0, 1);
        check("pre_rst_wr_en", int'(wr_en), 1);
        check("pre_rst_locked", int'(locked), 1);
        reset = 1'b1;
        #1;
        check("midrst_wr_en", int'(wr_en), 0);
        check("midrst_locked", int'(locked), 0);
        check("midrst_wr_addr", int'(wr_addr), 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        snap = wcnt0;
      end
    join
    #1;
    check("post_rst_writes", wcnt0 - snap, 0);
    check("post_rst_locked", int'(locked), 0);

    for (int i = 9; i < 11; i++) apply_vec(i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
